// File: rtl/fp_float2int.sv
// fp_float2int: pipelined IEEE-754-style float to signed integer converter.
// Rounds to nearest, ties to even, and saturates out-of-range results.
// Three register stages, one operation accepted per cycle, no stall.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous reset, active low
//   start_i      op_i is valid this cycle
//   op_i         packed float {sign, exponent, fraction}
//   done_o       one-cycle pulse when res_o and the flags are updated
//   res_o        two's-complement integer result, held until the next done
//   overflow_o   out-of-range magnitude or infinity (result saturated)
//   underflow_o  nonzero input that rounded to zero
//   exception_o  NaN input
module fp_float2int #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] op_i,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              exception_o
);

    localparam int MAN_W  = DATA_W - EXP_W;   // includes the hidden bit
    localparam int FRAC_W = MAN_W - 1;
    // Mantissa shifted left by up to DATA_W-2 positions.
    localparam int XW     = MAN_W + DATA_W - 1;

    localparam logic signed [EXP_W:0] BIAS_E = (EXP_W+1)'((1 << (EXP_W-1)) - 1);
    localparam logic signed [EXP_W:0] E_TOP  = (EXP_W+1)'(DATA_W - 1);

    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Valid bits for stages 1 and 2; done_o is the stage-3 valid.
    logic [1:0] vld_q;

    // ---------------- Stage 1: unpack ----------------
    logic              s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MAN_W-1:0]  s1_man_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q     <= '0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_man_q  <= '0;
        end else begin
            vld_q     <= {vld_q[0], start_i};
            s1_sign_q <= op_i[DATA_W-1];
            s1_exp_q  <= op_i[DATA_W-2 -: EXP_W];
            s1_man_q  <= {|op_i[DATA_W-2 -: EXP_W], op_i[FRAC_W-1:0]};
        end
    end

    // ---------------- Stage 2: classify and align ----------------
    logic [FRAC_W-1:0]        s1_frac;
    logic                     exp_ones;
    logic                     frac_nz;
    logic signed [EXP_W:0]    e;
    logic [XW-1:0]            x;
    logic [DATA_W-1:0]        int_d;
    logic                     grd_d, stk_d;
    logic                     big;

    assign s1_frac  = s1_man_q[FRAC_W-1:0];
    assign exp_ones = &s1_exp_q;
    assign frac_nz  = |s1_frac;
    assign e        = $signed({1'b0, s1_exp_q}) - BIAS_E;
    // Shift amount is only meaningful for 0 <= e < DATA_W-1.
    assign x        = {{(DATA_W-1){1'b0}}, s1_man_q} << e[EXP_W-1:0];
    assign big      = !e[EXP_W] && (e >= E_TOP);

    always_comb begin
        int_d = '0;
        grd_d = 1'b0;
        stk_d = 1'b0;
        if (e[EXP_W]) begin
            if (&e) begin
                // value in [0.5, 1): hidden bit is the guard
                grd_d = s1_man_q[MAN_W-1];
                stk_d = frac_nz;
            end else begin
                stk_d = |s1_man_q;
            end
        end else if (!big) begin
            // Binary point sits MAN_W-1 bits up from the bottom of x.
            int_d = x[XW-1:MAN_W-1];
            grd_d = x[MAN_W-2];
            stk_d = |x[MAN_W-3:0];
        end
    end

    logic              s2_sign_q;
    logic [DATA_W-1:0] s2_int_q;
    logic              s2_grd_q, s2_stk_q;
    logic              s2_nan_q, s2_sat_q, s2_min_q, s2_nz_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_sign_q <= 1'b0;
            s2_int_q  <= '0;
            s2_grd_q  <= 1'b0;
            s2_stk_q  <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_sat_q  <= 1'b0;
            s2_min_q  <= 1'b0;
            s2_nz_q   <= 1'b0;
        end else begin
            s2_sign_q <= s1_sign_q;
            s2_int_q  <= int_d;
            s2_grd_q  <= grd_d;
            s2_stk_q  <= stk_d;
            s2_nan_q  <= exp_ones && frac_nz;
            // -2^(DATA_W-1) exactly is representable; every other big
            // magnitude and infinity saturates.
            s2_min_q  <= !exp_ones && s1_sign_q && (e == E_TOP) && !frac_nz;
            s2_sat_q  <= (exp_ones && !frac_nz) ||
                         (!exp_ones && big && !(s1_sign_q && (e == E_TOP) && !frac_nz));
            s2_nz_q   <= (|s1_exp_q) || frac_nz;
        end
    end

    // ---------------- Stage 3: round, negate, saturate ----------------
    logic              rnd_up;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] res_d;
    logic              ovf_d, unf_d, exc_d;

    assign rnd_up = s2_grd_q & (s2_stk_q | s2_int_q[0]);
    // Aligned integer is below 2^(DATA_W-1), so the increment cannot wrap.
    assign mag    = s2_int_q + {{(DATA_W-1){1'b0}}, rnd_up};

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        exc_d = 1'b0;
        if (s2_nan_q) begin
            res_d = POS_MAX;
            exc_d = 1'b1;
        end else if (s2_sat_q) begin
            res_d = s2_sign_q ? NEG_MIN : POS_MAX;
            ovf_d = 1'b1;
        end else if (s2_min_q) begin
            res_d = NEG_MIN;
        end else if (!s2_sign_q && mag[DATA_W-1]) begin
            res_d = POS_MAX;
            ovf_d = 1'b1;
        end else begin
            // -0 negates to 0, so no signed zero can appear here.
            res_d = s2_sign_q ? (~mag + 1'b1) : mag;
            unf_d = s2_nz_q && (mag == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_o      <= 1'b0;
            res_o       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            exception_o <= 1'b0;
        end else begin
            done_o <= vld_q[1];
            if (vld_q[1]) begin
                res_o       <= res_d;
                overflow_o  <= ovf_d;
                underflow_o <= unf_d;
                exception_o <= exc_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_float2int.sv
// Self-checking bench for fp_float2int (DATA_W=32, EXP_W=8).
// A remainder-based round-to-nearest-even model predicts each result; one
// compare process checks done/res/flags every cycle against it.
module tb_fp_float2int;

    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        ex;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] op;
    logic        done;
    logic [31:0] res;
    logic        overflow, underflow, exception;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;
    int cyc    = 0;

    out_t slot_o [8];
    bit   slot_v [8];
    out_t hold;

    always #5 clk = ~clk;

    fp_float2int #(.DATA_W(32), .EXP_W(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .op_i       (op),
        .done_o     (done),
        .res_o      (res),
        .overflow_o (overflow),
        .underflow_o(underflow),
        .exception_o(exception)
    );

    // Reference: value = man * 2^(e-23), rounded with an exact remainder test.
    function automatic out_t model(input logic [31:0] f);
        out_t   o;
        bit     s;
        int     ex, e, sh;
        longint man, q, r, half, one;
        s   = f[31];
        ex  = int'(f[30:23]);
        man = longint'(f[22:0]);
        one = 1;
        o   = '0;
        if (ex == 255) begin
            if (man != 0) begin
                o.res = 32'h7FFF_FFFF; o.ex = 1'b1;
            end else begin
                o.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF; o.ov = 1'b1;
            end
            return o;
        end
        if (ex != 0) man = man + (one << 23);
        e = ex - 127;
        if (e >= 31) begin
            if (s && e == 31 && f[22:0] == 0) o.res = 32'h8000_0000;
            else begin
                o.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF; o.ov = 1'b1;
            end
            return o;
        end
        if (e >= 23) q = man << (e - 23);
        else begin
            sh = 23 - e;
            if (sh > 60) sh = 60;
            q    = man >> sh;
            r    = man - (q << sh);
            half = one << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
        end
        if (!s && q >= (one << 31)) begin
            o.res = 32'h7FFF_FFFF; o.ov = 1'b1;
            return o;
        end
        o.res = s ? 32'(-q) : 32'(q);
        o.un  = (f[30:0] != 0) && (q == 0);
        return o;
    endfunction

    // Scheduler: a start sampled at edge k is due on the outputs after edge k+2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) slot_v[i] <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            slot_v[(cyc + 3) % 8] <= start;
            slot_o[(cyc + 3) % 8] <= model(op);
        end
    end

    // Compare process: every cycle, between edges.
    initial begin
        out_t exp_o;
        bit   exp_d;
        hold = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold  = '0;
                exp_d = 1'b0;
            end else begin
                exp_d = slot_v[cyc % 8];
                if (exp_d) hold = slot_o[cyc % 8];
            end
            exp_o = hold;
            n_chk++;
            if (done === exp_d && res === exp_o.res && overflow === exp_o.ov &&
                underflow === exp_o.un && exception === exp_o.ex)
                n_pass++;
            else begin
                n_fail++;
                $display("FAIL out_cyc%0d: got done=%b res=%h ov=%b un=%b ex=%b, want done=%b res=%h ov=%b un=%b ex=%b",
                         cyc, done, res, overflow, underflow, exception,
                         exp_d, exp_o.res, exp_o.ov, exp_o.un, exp_o.ex);
            end
        end
    end

    task automatic issue(input logic [31:0] f);
        @(negedge clk);
        start = 1'b1;
        op    = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            op    = $urandom;
        end
    endtask

    // Hand-computed expectations that pin the model.
    logic [31:0] pin_op  [10] = '{32'h3F80_0000, 32'h4020_0000, 32'h4060_0000, 32'hC020_0000,
                                  32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000,
                                  32'h3E80_0000, 32'h8000_0000};
    out_t        pin_exp [10] = '{{32'h0000_0001, 3'b000}, {32'h0000_0002, 3'b000},
                                  {32'h0000_0004, 3'b000}, {32'hFFFF_FFFE, 3'b000},
                                  {32'h7FFF_FFFF, 3'b100}, {32'h8000_0000, 3'b000},
                                  {32'h8000_0000, 3'b100}, {32'h7FFF_FFFF, 3'b001},
                                  {32'h0000_0000, 3'b010}, {32'h0000_0000, 3'b000}};

    initial begin
        out_t m;
        logic [31:0] f;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;

        for (int i = 0; i < 10; i++) begin
            m = model(pin_op[i]);
            n_chk++;
            if (m === pin_exp[i]) n_pass++;
            else begin
                n_fail++;
                $display("FAIL pin_%0d op=%h: model res=%h flags=%b, want res=%h flags=%b",
                         i, pin_op[i], m.res, {m.ov, m.un, m.ex},
                         pin_exp[i].res, {pin_exp[i].ov, pin_exp[i].un, pin_exp[i].ex});
            end
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed: 1.0, ties back-to-back, range limits, specials.
        issue(32'h3F80_0000);
        idle(4);
        for (int i = 1; i < 4; i++) issue(pin_op[i]);
        idle(4);
        for (int i = 4; i < 10; i++) begin
            issue(pin_op[i]);
            idle(1);
        end
        idle(4);

        // Reset one cycle after a start: no done, outputs clear at once.
        issue(32'h42F6_0000);   // 123.0
        idle(5);
        issue(32'h40E0_0000);   // 7.0
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        issue(32'h4140_0000);   // 12.0, first op after reset
        idle(4);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 4))
                0: f = $urandom;
                1: f = {1'($urandom), 8'($urandom_range(100, 160)), 23'($urandom)};
                2: f = {1'($urandom), 8'($urandom_range(150, 160)), 23'($urandom)};
                3: f = {1'($urandom), 8'($urandom_range(126, 150)), 23'($urandom) & 23'h7F_FC00};
                default: f = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                              ($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'h0};
            endcase
            @(negedge clk);
            start = ($urandom_range(0, 9) != 0);
            op    = f;
            if (i == 5000) begin
                start = 1'b0;
                rst_n = 1'b0;
                idle(2);
                rst_n = 1'b1;
            end
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_float2int.md
FP_FLOAT2INT -- requirements
Module: fp_float2int

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the float input and the integer output.
REQ-002 Parameter EXP_W, default 8, SHALL set the exponent width; MAN_W = DATA_W-EXP_W (includes hidden bit); BIAS = 2^(EXP_W-1)-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 rst  input  1  SHALL be the asynchronous reset, active low.
REQ-006 start  input  1  SHALL mark op as valid for one cycle; it may be high every cycle.
REQ-007 op  input  DATA_W  SHALL be the IEEE-754-style packed float {sign, exponent, fraction}.
REQ-008 done  output  1  SHALL be a registered, one-cycle pulse per accepted start.
REQ-009 res  output  DATA_W  SHALL be the signed two's-complement integer result (registered).
REQ-010 overflow  output  1  SHALL flag a result that is out of range or comes from an infinity.
REQ-011 underflow  output  1  SHALL flag a nonzero input whose result rounds to 0.
REQ-012 exception  output  1  SHALL flag a NaN input.

Function
REQ-013 The block SHALL be fully pipelined with 3 register stages and accept one operation per cycle: start at edge N gives done, res and flags valid after edge N+3.
REQ-014 Stage 1 SHALL register sign, biased exponent and mantissa; the hidden bit SHALL be 1 when exponent != 0 and 0 otherwise.
REQ-015 Stage 2 SHALL compute e = exponent-BIAS (signed, EXP_W+1 bits) and align the mantissa to an integer plus guard and sticky bits.
- e < -1: integer 0, guard 0, sticky = |mantissa.
- e == -1: integer 0, guard = hidden bit, sticky = |fraction.
- 0 <= e < DATA_W-1: integer = mantissa shifted by e-(MAN_W-1); bits shifted out form guard (MSB dropped) and sticky (OR of the rest).
REQ-016 Stage 3 SHALL round to nearest, ties to even: increment when guard & (sticky | integer LSB). It SHALL then negate if sign=1 and saturate.
REQ-017 Saturation: a positive overflow SHALL give 2^(DATA_W-1)-1, and a negative overflow SHALL give -2^(DATA_W-1); overflow=1 in both cases.
REQ-018 Overflow cases:
- exponent all-ones with fraction 0 (infinity);
- e >= DATA_W-1, except for exactly -2^(DATA_W-1) (sign=1, e=DATA_W-1, fraction=0), which SHALL give 0x80000000 with overflow=0;
- a positive rounded magnitude equal to 2^(DATA_W-1).
REQ-019 NaN (exponent all-ones, fraction != 0) SHALL give res = 2^(DATA_W-1)-1, exception=1, overflow=0, underflow=0.
REQ-020 Zero inputs (±0) SHALL give res=0 with all flags 0; -0 SHALL NOT produce a negative result.
REQ-021 Denormals and any nonzero input that rounds to 0 SHALL give res=0 with underflow=1.
REQ-022 res and the flags SHALL hold their last value until the next done; done SHALL be low in all other cycles.
REQ-023 Pipeline stages SHALL advance every cycle with no stall; data in stages without a pending start is don't-care but SHALL NOT pulse done.

Reset
REQ-024 On rst low, all pipeline registers, done, res and the flags SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-025 Operations in flight when reset asserts SHALL be discarded with no done pulse.
REQ-026 The first start accepted after reset releases SHALL complete in 3 cycles.

Verification
REQ-027 op=0x3F800000 (1.0), start at cycle 0 -> done at cycle 3, res=0x00000001, flags 0.
REQ-028 Rounding ties to even:
- 0x40200000 (2.5) -> res=0x00000002;
- 0x40600000 (3.5) -> res=0x00000004;
- 0xC0200000 (-2.5) -> res=0xFFFFFFFE.
All three are issued back-to-back and must give three consecutive done pulses.
REQ-029 Range limits:
- 0x4F000000 (2^31) -> res=0x7FFFFFFF, overflow=1;
- 0xCF000000 (-2^31) -> res=0x80000000, overflow=0;
- 0xFF800000 (-inf) -> res=0x80000000, overflow=1.
REQ-030 Special inputs:
- 0x7FC00000 (NaN) -> res=0x7FFFFFFF, exception=1;
- 0x3E800000 (0.25) -> res=0, underflow=1;
- 0x80000000 (-0) -> res=0, flags 0.
REQ-031 Assert rst low one cycle after a start -> done never pulses for that op, and res=0 immediately.
REQ-032 10k random floats checked against a reference model (RNE conversion with saturation), with latency exactly 3.
